tlb_op_ctrl: RTL and testbench

Multi-cycle sequencer for the TLB management instructions (TLBP, TLBR, TLBWI, TLBWR), issued from the MEM stage.
- Stalls the pipeline while an operation runs.
- Drives the search, read and write ports of the registered TLB array.
- Emits one-cycle update strobes to CP0: an Index load and an EntryHi/EntryLo0/EntryLo1/PageMask load.
- Owns the CP0 Random register.

---
 rtl/tlb_op_ctrl_if.sv | 46 ++++
 rtl/tlb_op_ctrl.sv | 150 +++++++++++++++
 tb/tb_tlb_op_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_op_ctrl_if.sv
// Bundles the TLB-instruction handshake between the MEM stage, CP0 and the TLB
// array for the TLB op sequencer. The slave modport is the sequencer's view.
interface tlb_op_ctrl_if #(
    parameter int IDX_W = 4
);
    // pipeline / CP0 side
    logic              op_valid_i;
    logic [1:0]        op_type_i;
    logic              flush_i;
    logic [IDX_W-1:0]  index_i;
    logic [31:0]       entryhi_i;
    logic [IDX_W-1:0]  wired_i;
    logic              wired_we_i;
    logic              stall_o;
    logic              done_o;
    // TLB array side
    logic              tlb_srch_o;
    logic [18:0]       tlb_vpn2_o;
    logic [7:0]        tlb_asid_o;
    logic              tlb_hit_i;
    logic [IDX_W-1:0]  tlb_hit_idx_i;
    logic              tlb_rd_o;
    logic [IDX_W-1:0]  tlb_idx_o;
    logic              tlb_we_o;
    // CP0 update strobes
    logic              cp0_idx_we_o;
    logic [31:0]       cp0_idx_o;
    logic              cp0_ent_we_o;
    logic [IDX_W-1:0]  random_o;

    modport slave (
        input  op_valid_i, op_type_i, flush_i, index_i, entryhi_i,
        input  wired_i, wired_we_i, tlb_hit_i, tlb_hit_idx_i,
        output stall_o, done_o, tlb_srch_o, tlb_vpn2_o, tlb_asid_o,
        output tlb_rd_o, tlb_idx_o, tlb_we_o,
        output cp0_idx_we_o, cp0_idx_o, cp0_ent_we_o, random_o
    );

    modport master (
        output op_valid_i, op_type_i, flush_i, index_i, entryhi_i,
        output wired_i, wired_we_i, tlb_hit_i, tlb_hit_idx_i,
        input  stall_o, done_o, tlb_srch_o, tlb_vpn2_o, tlb_asid_o,
        input  tlb_rd_o, tlb_idx_o, tlb_we_o,
        input  cp0_idx_we_o, cp0_idx_o, cp0_ent_we_o, random_o
    );
endinterface

// File: rtl/tlb_op_ctrl.sv
// Multi-cycle sequencer for TLBP/TLBR/TLBWI/TLBWR issued from MEM.
// Drives the registered TLB array ports, raises one-cycle CP0 update strobes
// and owns the CP0 Random register. Strobes decode from registered state and
// are only gated combinationally by flush.
module tlb_op_ctrl #(
    parameter int TLB_ENTRIES = 16,
    parameter int IDX_W       = 4
) (
    input  logic         clk,
    input  logic         rst,
    tlb_op_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_TLBP  = 2'b00;
    localparam logic [1:0] OP_TLBR  = 2'b01;

    localparam logic [IDX_W-1:0] RAND_MAX = IDX_W'(TLB_ENTRIES - 1);
    localparam logic [31:0]      MISS_IDX = 32'h8000_0000;

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_op;
    logic [IDX_W-1:0] r_idx;
    logic [18:0]      r_vpn2;
    logic [7:0]       r_asid;
    logic [31:0]      r_res;
    logic [IDX_W-1:0] r_rand;

    logic             w_accept;
    logic             w_is_p;
    logic             w_is_r;
    logic             w_is_w;
    logic             w_flush;
    logic [IDX_W-1:0] w_rand_nxt;
    logic             w_wired_hi;
    logic             w_unused_eh;

    // EntryHi bits between ASID and VPN2 carry nothing for the TLB ops
    assign w_unused_eh = ^bus.entryhi_i[12:8];

    assign w_flush  = bus.flush_i;
    assign w_accept = (r_state == S_IDLE) && bus.op_valid_i && !w_flush;
    assign w_is_p   = (r_op == OP_TLBP);
    assign w_is_r   = (r_op == OP_TLBR);
    assign w_is_w   = r_op[1];

    // state register; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // next-state and flush-gated strobe decode
    always_comb begin
        w_next           = r_state;
        bus.stall_o      = 1'b0;
        bus.done_o       = 1'b0;
        bus.tlb_srch_o   = 1'b0;
        bus.tlb_rd_o     = 1'b0;
        bus.tlb_we_o     = 1'b0;
        bus.cp0_idx_we_o = 1'b0;
        bus.cp0_ent_we_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                // the accept cycle stalls too, so MEM holds the instruction
                bus.stall_o = w_accept;
                if (w_accept) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                bus.stall_o    = 1'b1;
                bus.tlb_srch_o = w_is_p && !w_flush;
                bus.tlb_rd_o   = w_is_r && !w_flush;
                // never let a flushed write reach the array
                bus.tlb_we_o   = w_is_w && !w_flush;
                if (w_flush)     w_next = S_IDLE;
                else if (w_is_w) w_next = S_DONE;
                else             w_next = S_WAIT;
            end
            S_WAIT: begin
                bus.stall_o = 1'b1;
                w_next      = w_flush ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                bus.done_o       = !w_flush;
                bus.cp0_idx_we_o = w_is_p && !w_flush;
                bus.cp0_ent_we_o = w_is_r && !w_flush;
                w_next           = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // operation context captured at accept; TLBWR targets the current Random
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op   <= 2'b00;
            r_idx  <= '0;
            r_vpn2 <= '0;
            r_asid <= '0;
        end else if (w_accept) begin
            r_op   <= bus.op_type_i;
            r_idx  <= (bus.op_type_i == 2'b11) ? r_rand : bus.index_i;
            r_vpn2 <= bus.entryhi_i[31:13];
            r_asid <= bus.entryhi_i[7:0];
        end
    end

    // probe result: hit index zero-extended, or the P bit on a miss
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res <= '0;
        end else if (r_state == S_WAIT && w_is_p && !w_flush) begin
            r_res <= bus.tlb_hit_i ? {{(32-IDX_W){1'b0}}, bus.tlb_hit_idx_i}
                                   : MISS_IDX;
        end
    end

    // Random next value: counts down through [wired, TLB_ENTRIES-1] while idle
    always_comb begin
        w_wired_hi = ({1'b0, bus.wired_i} >= {1'b0, RAND_MAX});
        w_rand_nxt = r_rand;
        if (bus.wired_we_i) begin
            w_rand_nxt = RAND_MAX;
        end else if (r_state == S_IDLE && !w_accept) begin
            if (w_wired_hi || r_rand == bus.wired_i || r_rand == '0)
                w_rand_nxt = RAND_MAX;
            else
                w_rand_nxt = r_rand - 1'b1;
        end
    end

    // Random register; frozen while an operation is in flight
    always_ff @(posedge clk) begin
        if (rst) r_rand <= RAND_MAX;
        else     r_rand <= w_rand_nxt;
    end

    assign bus.tlb_vpn2_o = r_vpn2;
    assign bus.tlb_asid_o = r_asid;
    assign bus.tlb_idx_o  = r_idx;
    assign bus.cp0_idx_o  = r_res;
    assign bus.random_o   = r_rand;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Bench for tlb_op_ctrl: a small TLB array model answers searches, expected
// array/CP0 events are queued at issue and popped when the DUT emits them.
module tb_tlb_op_ctrl;
    localparam int IDX_W = 4;
    localparam logic [1:0] OP_P = 2'b00, OP_R = 2'b01, OP_WI = 2'b10, OP_WR = 2'b11;
    localparam logic [2:0] K_NONE = 3'd0, K_SRCH = 3'd1, K_RD = 3'd2, K_WE = 3'd3, K_DONE = 3'd4;

    typedef struct {
        logic [2:0]  kind;
        logic [31:0] val;
        logic [1:0]  flg;
    } ev_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;
    ev_t  sb_q[$];

    logic [18:0] m_vpn2 [16];
    logic [7:0]  m_asid [16];

    tlb_op_ctrl_if #(.IDX_W(IDX_W)) bus ();

    tlb_op_ctrl #(.TLB_ENTRIES(16), .IDX_W(IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // TLB array model: {hit, idx}
    function automatic logic [4:0] lookup(input logic [18:0] vpn2, input logic [7:0] asid);
        lookup = 5'd0;
        for (int i = 0; i < 16; i++)
            if (m_vpn2[i] == vpn2 && m_asid[i] == asid) lookup = {1'b1, 4'(i)};
    endfunction

    // search response one cycle after the request
    always @(posedge clk) begin
        if (rst) begin
            bus.tlb_hit_i     <= 1'b0;
            bus.tlb_hit_idx_i <= '0;
        end else begin
            logic [4:0] r;
            r = lookup(bus.tlb_vpn2_o, bus.tlb_asid_o);
            bus.tlb_hit_i     <= bus.tlb_srch_o && r[4];
            bus.tlb_hit_idx_i <= r[3:0];
        end
    end

    // event monitor: any strobe must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            ev_t o;
            o.kind = K_NONE; o.val = '0; o.flg = '0;
            if (bus.tlb_srch_o) begin
                o.kind = K_SRCH; o.val = {5'd0, bus.tlb_vpn2_o, bus.tlb_asid_o};
            end else if (bus.tlb_rd_o) begin
                o.kind = K_RD; o.val = {28'd0, bus.tlb_idx_o};
            end else if (bus.tlb_we_o) begin
                o.kind = K_WE; o.val = {28'd0, bus.tlb_idx_o};
            end else if (bus.done_o || bus.cp0_idx_we_o || bus.cp0_ent_we_o) begin
                o.kind = K_DONE;
                o.val  = bus.cp0_idx_we_o ? bus.cp0_idx_o : 32'd0;
                o.flg  = {bus.cp0_idx_we_o, bus.cp0_ent_we_o};
            end
            if (o.kind != K_NONE) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_kind", {29'd0, o.kind}, {29'd0, K_NONE});
                end else begin
                    ev_t e;
                    e = sb_q.pop_front();
                    chk("sb_kind", {29'd0, o.kind}, {29'd0, e.kind});
                    chk("sb_val", o.val, e.val);
                    chk("sb_flg", {30'd0, o.flg}, {30'd0, e.flg});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [2:0] k, input logic [31:0] v, input logic [1:0] f);
        ev_t e;
        e.kind = k; e.val = v; e.flg = f;
        sb_q.push_back(e);
    endtask

    // queue the events an unflushed op must produce
    task automatic expect_op(input logic [1:0] op, input logic [3:0] tgt, input logic [31:0] eh);
        logic [4:0] r;
        r = lookup(eh[31:13], eh[7:0]);
        case (op)
            OP_P: begin
                push(K_SRCH, {5'd0, eh[31:13], eh[7:0]}, 2'b00);
                push(K_DONE, r[4] ? {28'd0, r[3:0]} : 32'h8000_0000, 2'b10);
            end
            OP_R: begin
                push(K_RD, {28'd0, tgt}, 2'b00);
                push(K_DONE, 32'd0, 2'b01);
            end
            default: begin
                push(K_WE, {28'd0, tgt}, 2'b00);
                push(K_DONE, 32'd0, 2'b00);
            end
        endcase
    endtask

    // full op with stall/done timing; exp_rand < 0 skips the Random check
    task automatic run_op(input logic [1:0] op, input logic [3:0] idx, input logic [3:0] tgt,
                          input logic [31:0] eh, input int exp_rand);
        int lat;
        lat = op[1] ? 2 : 3;
        expect_op(op, tgt, eh);
        bus.op_valid_i = 1'b1;
        bus.op_type_i  = op;
        bus.index_i    = idx;
        bus.entryhi_i  = eh;
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            chk($sformatf("stall_T%0d", c), {31'd0, bus.stall_o}, {31'd0, (c < lat)});
            chk($sformatf("done_T%0d", c), {31'd0, bus.done_o}, {31'd0, (c == lat)});
            if (exp_rand >= 0) chk($sformatf("rand_T%0d", c), {28'd0, bus.random_o}, 32'(exp_rand));
            tick();
            bus.op_valid_i = 1'b0;
        end
    endtask

    task automatic wait_rand(input logic [3:0] v);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (bus.random_o == v) found = 1'b1;
        end
        chk("rand_wait", {31'd0, found}, 32'd1);
    endtask

    initial begin
        int rseq [6];
        rseq = '{5, 4, 3, 2, 15, 14};
        n_chk = 0;
        n_err = 0;
        for (int i = 0; i < 16; i++) begin
            m_vpn2[i] = 19'h70000 + 19'(i);
            m_asid[i] = 8'hff;
        end
        m_vpn2[7] = 19'h00201;
        m_asid[7] = 8'h05;

        rst = 1'b1;
        bus.op_valid_i = 1'b0; bus.op_type_i = 2'b00; bus.flush_i = 1'b0;
        bus.index_i = '0; bus.entryhi_i = '0; bus.wired_i = '0; bus.wired_we_i = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_stall", {31'd0, bus.stall_o}, 32'd0);
        chk("rst_random", {28'd0, bus.random_o}, 32'd15);
        chk("rst_cp0_idx", bus.cp0_idx_o, 32'd0);
        chk("rst_tlb_idx", {28'd0, bus.tlb_idx_o}, 32'd0);
        tick();
        rst = 1'b0;

        // TLBP hit on entry 7, then miss
        run_op(OP_P, 4'd0, 4'd0, 32'h0040_2005, -1);
        @(negedge clk);
        chk("p_hit_idx_held", bus.cp0_idx_o, 32'h0000_0007);
        tick();
        run_op(OP_P, 4'd0, 4'd0, 32'h1234_5077, -1);

        // TLBWR with Wired=2 taken at Random=5, then Random sequence
        bus.wired_i = 4'd2;
        bus.wired_we_i = 1'b1;
        tick();
        bus.wired_we_i = 1'b0;
        wait_rand(4'd5);
        run_op(OP_WR, 4'd0, 4'd5, 32'h0, 5);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("rand_seq%0d", i), {28'd0, bus.random_o}, 32'(rseq[i]));
            tick();
        end

        // TLBR index 3 and TLBWI index 9
        run_op(OP_R, 4'd3, 4'd3, 32'h0, -1);
        run_op(OP_WI, 4'd9, 4'd9, 32'h0, -1);

        // flush in ISSUE of a TLBWI: nothing queued, no strobes expected
        bus.op_valid_i = 1'b1; bus.op_type_i = OP_WI; bus.index_i = 4'd6;
        tick();
        bus.op_valid_i = 1'b0;
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        @(negedge clk);
        chk("fl_issue_stall", {31'd0, bus.stall_o}, 32'd0);
        chk("fl_issue_done", {31'd0, bus.done_o}, 32'd0);
        tick();
        // idle right away: a fresh op is accepted with normal timing
        run_op(OP_R, 4'd2, 4'd2, 32'h0, -1);

        // flush in DONE of a TLBP: search happens, CP0 load suppressed
        push(K_SRCH, {5'd0, 19'h00201, 8'h05}, 2'b00);
        bus.op_valid_i = 1'b1; bus.op_type_i = OP_P; bus.entryhi_i = 32'h0040_2005;
        tick();
        bus.op_valid_i = 1'b0;
        tick();
        tick();
        bus.flush_i = 1'b1;
        @(negedge clk);
        chk("fl_done_idx_we", {31'd0, bus.cp0_idx_we_o}, 32'd0);
        chk("fl_done_done", {31'd0, bus.done_o}, 32'd0);
        tick();
        bus.flush_i = 1'b0;

        // Wired write reloads Random from 9
        wait_rand(4'd9);
        bus.wired_we_i = 1'b1;
        tick();
        bus.wired_we_i = 1'b0;
        chk("wired_we_rand", {28'd0, bus.random_o}, 32'd15);

        // reset while a TLBP sits in WAIT
        wait_rand(4'd7);
        push(K_SRCH, {5'd0, 19'h00201, 8'h05}, 2'b00);
        bus.op_valid_i = 1'b1; bus.op_type_i = OP_P; bus.entryhi_i = 32'h0040_2005;
        tick();
        bus.op_valid_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rstw_stall", {31'd0, bus.stall_o}, 32'd0);
        chk("rstw_done", {31'd0, bus.done_o}, 32'd0);
        chk("rstw_strobes", {27'd0, bus.tlb_srch_o, bus.tlb_rd_o, bus.tlb_we_o,
                             bus.cp0_idx_we_o, bus.cp0_ent_we_o}, 32'd0);
        chk("rstw_vpn2", {13'd0, bus.tlb_vpn2_o}, 32'd0);
        chk("rstw_asid", {24'd0, bus.tlb_asid_o}, 32'd0);
        chk("rstw_cp0_idx", bus.cp0_idx_o, 32'd0);
        chk("rstw_random", {28'd0, bus.random_o}, 32'd15);
        tick();
        // back in IDLE: a write completes with its short latency
        run_op(OP_WI, 4'd1, 4'd1, 32'h0, -1);

        repeat (3) tick();
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
